fpdp_div_requester: RTL

//  Initiator side of the fpdp_division operand/result handshake: accepts FP64 dividend/divisor jobs

---
 rtl/fpdp_div_pkg.sv | 32 +++
 rtl/fpdp_div_special.sv | 31 +++
 rtl/fpdp_div_requester.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fpdp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpdp_div_pkg
// Description : Shared FP64 constants, field positions, requester state
//               encoding and the tag sequencing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fpdp_div_pkg;

    localparam logic [63:0] c_QNAN    = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] c_POS_INF = 64'h7FF0_0000_0000_0000;
    localparam logic [10:0] c_EXP_MAX = 11'h7FF;

    localparam int c_SIGN_BIT = 63;
    localparam int c_EXP_MSB  = 62;
    localparam int c_EXP_LSB  = 52;
    localparam int c_MANT_MSB = 51;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_WAIT    = 2'd1;
    localparam state_t c_ST_DELIVER = 2'd2;

    // Tag 0 means "no request", so the sequence wraps from the max tag back to 1.
    function automatic logic [31:0] next_tag(input logic [31:0] tag, input int unsigned tag_w);
        logic [31:0] max_tag;
        max_tag = (32'd1 << tag_w) - 32'd1;
        return (tag >= max_tag) ? 32'd1 : tag + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpdp_div_special.sv
`default_nettype none
// ============================================================================
// Module      : fpdp_div_special
// Description : Divide-by-zero detect and bypass quotient (signed infinity,
//               or quiet NaN for 0/0 and NaN/0).
// Revision    : 1.0 - initial release
// ============================================================================
module fpdp_div_special
    import fpdp_div_pkg::*;
(
    input  logic [63:0] i_dividend,
    input  logic [63:0] i_divisor,
    output logic        o_divisor_zero,
    output logic [63:0] o_bypass_quotient
);

    logic w_dividend_zero;
    logic w_dividend_nan;
    logic w_sign;

    assign o_divisor_zero  = (i_divisor[c_EXP_MSB:0] == '0);
    assign w_dividend_zero = (i_dividend[c_EXP_MSB:0] == '0);
    assign w_dividend_nan  = (i_dividend[c_EXP_MSB:c_EXP_LSB] == c_EXP_MAX) &&
                             (i_dividend[c_MANT_MSB:0] != '0);
    assign w_sign          = i_dividend[c_SIGN_BIT] ^ i_divisor[c_SIGN_BIT];

    assign o_bypass_quotient = (w_dividend_zero || w_dividend_nan) ? c_QNAN
                                                                   : {w_sign, c_POS_INF[c_EXP_MSB:0]};

endmodule
`default_nettype wire

// File: rtl/fpdp_div_requester.sv
`default_nettype none
// ============================================================================
// Module      : fpdp_div_requester
// Description : Issues one FP64 divide job at a time to the fpdp divider via
//               a tagged request/done handshake and returns the quotient on a
//               valid/ready stream. Optional watchdog: FPDP_DIV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpdp_div_requester
    import fpdp_div_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 256
)
(
    input  logic             clk,
    input  logic             rset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_dividend,
    input  logic [63:0]      in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_quotient,
    output logic             out_dz,
    output logic             out_err,
    output logic [63:0]      div_dividend,
    output logic [63:0]      div_divisor,
    output logic [TAG_W-1:0] div_ready,
    input  logic [TAG_W-1:0] div_done,
    input  logic [63:0]      div_quotient
);

    state_t           r_state;
    state_t           w_state_next;
    logic [TAG_W-1:0] r_tag;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [63:0]      r_out_quotient;
    logic             r_out_dz;
    logic             r_out_err;
    logic [63:0]      r_div_dividend;
    logic [63:0]      r_div_divisor;
    logic [TAG_W-1:0] r_div_ready;

    logic             w_accept;
    logic             w_match;
    logic             w_timeout;
    logic             w_release;
    logic             w_div_by_zero;
    logic [63:0]      w_bypass_q;

    if (TAG_W < 1 || TAG_W > 31 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fpdp_div_requester: illegal TAG_W or TIMEOUT_CYC");
    end

    fpdp_div_special u_special (
        .i_dividend        (in_dividend),
        .i_divisor         (in_divisor),
        .o_divisor_zero    (w_div_by_zero),
        .o_bypass_quotient (w_bypass_q)
    );

    assign w_accept  = in_valid && r_in_ready && (r_state == c_ST_IDLE);
    assign w_match   = (r_state == c_ST_WAIT) && (div_done == r_tag);
    assign w_release = (r_state == c_ST_DELIVER) && r_out_valid && out_ready;

`ifdef FPDP_DIV_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [c_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rset || w_accept) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // A match in the final cycle wins over the watchdog.
    assign w_timeout = (r_state == c_ST_WAIT) && !w_match &&
                       (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept) w_state_next = w_div_by_zero ? c_ST_DELIVER : c_ST_WAIT;
            c_ST_WAIT:    if (w_match || w_timeout) w_state_next = c_ST_DELIVER;
            c_ST_DELIVER: if (w_release) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            r_tag          <= TAG_W'(1);
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_quotient <= '0;
            r_out_dz       <= 1'b0;
            r_out_err      <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_ready    <= '0;
        end else begin
            r_in_ready  <= (w_state_next == c_ST_IDLE);
            r_out_valid <= (w_state_next == c_ST_DELIVER);
            if (w_accept) begin
                if (w_div_by_zero) begin
                    r_out_quotient <= w_bypass_q;
                    r_out_dz       <= 1'b1;
                    r_out_err      <= 1'b0;
                end else begin
                    r_div_dividend <= in_dividend;
                    r_div_divisor  <= in_divisor;
                    r_div_ready    <= r_tag;
                end
            end
            if (w_match || w_timeout) begin
                r_out_quotient <= w_match ? div_quotient : c_QNAN;
                r_out_dz       <= 1'b0;
                r_out_err      <= w_timeout;
                r_div_ready    <= '0;
                r_tag          <= TAG_W'(next_tag(32'(r_tag), TAG_W));
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_quotient = r_out_quotient;
    assign out_dz       = r_out_dz;
    assign out_err      = r_out_err;
    assign div_dividend = r_div_dividend;
    assign div_divisor  = r_div_divisor;
    assign div_ready    = r_div_ready;

endmodule
`default_nettype wire
